// File: rtl/fluxo_dados_param_if.sv
// Control-unit <-> datapath bundle for the memory-sequence game datapath.
// master = control unit (drives clears/enables/buttons), slave = datapath.
interface fluxo_dados_param_if #(
    parameter int unsigned N = 4,
    parameter int unsigned A = 4
);
    logic [N-1:0] botoes;
    logic         zeraE;
    logic         zeraL;
    logic         zeraR;
    logic         zeraTMR;
    logic         contaE;
    logic         contaL;
    logic         contaTMR;
    logic         registraR;
    logic         escreveM;
    logic         fimE;
    logic         fimL;
    logic         fimTMR;
    logic         jogada_feita;
    logic         jogada_valida;
    logic         chavesIgualMemoria;
    logic         enderecoIgualLimite;
    logic         enderecoMenorLimite;
    logic         timeout;
    logic         db_tem_jogada;
    logic [A-1:0] db_contagem;
    logic [A-1:0] db_limite;
    logic [N-1:0] db_jogada;
    logic [N-1:0] db_memoria;

    modport master (
        output botoes, zeraE, zeraL, zeraR, zeraTMR, contaE, contaL, contaTMR,
               registraR, escreveM,
        input  fimE, fimL, fimTMR, jogada_feita, jogada_valida, chavesIgualMemoria,
               enderecoIgualLimite, enderecoMenorLimite, timeout, db_tem_jogada,
               db_contagem, db_limite, db_jogada, db_memoria
    );

    modport slave (
        input  botoes, zeraE, zeraL, zeraR, zeraTMR, contaE, contaL, contaTMR,
               registraR, escreveM,
        output fimE, fimL, fimTMR, jogada_feita, jogada_valida, chavesIgualMemoria,
               enderecoIgualLimite, enderecoMenorLimite, timeout, db_tem_jogada,
               db_contagem, db_limite, db_jogada, db_memoria
    );
endinterface

// File: rtl/fluxo_dados_param.sv
// Parametrised memory-game datapath: counters, button register, write-first sequence memory,
// play-edge detector and display timer. Define TIMEOUT_EN to build the inactivity timeout.
module fluxo_dados_param #(
    parameter int unsigned N         = 4,
    parameter int unsigned A         = 4,
    parameter int unsigned TIMEOUT_M = 5000,
    parameter int unsigned TMR_M     = 500
) (
    input logic               clock,
    input logic               reset,
    fluxo_dados_param_if.slave dp
);
    localparam int unsigned DEPTH = 1 << A;
    localparam int unsigned TMRW  = (TMR_M > 1) ? $clog2(TMR_M) : 1;

    function automatic logic [DEPTH*N-1:0] mem_init();
        logic [DEPTH*N-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            v[i*N +: N] = N'(1) << (i % N);
        end
        return v;
    endfunction

    localparam logic [DEPTH-1:0][N-1:0] MemInit = mem_init();

    if (TIMEOUT_M < 2 || TMR_M < 2) begin : g_param_check
        $error("fluxo_dados_param: TIMEOUT_M and TMR_M must be at least 2");
    end

    logic [A-1:0]    e_q, l_q;
    logic [N-1:0]    r_q, d_q;
    logic            p_q;
    logic [TMRW-1:0] m_q;
    // Memory holds its contents across reset; only the power-up image initialises it.
    logic [DEPTH-1:0][N-1:0] mem_q = MemInit;

    always_ff @(posedge clock) begin
        if (!reset) begin
            e_q <= '0;
            l_q <= '0;
            r_q <= '0;
            d_q <= '0;
            p_q <= 1'b0;
            m_q <= '0;
        end else begin
            if (dp.zeraE)       e_q <= '0;
            else if (dp.contaE) e_q <= e_q + 1'b1;

            if (dp.zeraL)       l_q <= '0;
            else if (dp.contaL) l_q <= l_q + 1'b1;

            if (dp.zeraR)          r_q <= '0;
            else if (dp.registraR) r_q <= dp.botoes;

            if (dp.zeraTMR)       m_q <= '0;
            else if (dp.contaTMR) m_q <= (m_q == TMRW'(TMR_M - 1)) ? '0 : m_q + 1'b1;

            // Write-first: a word being written shows up on D at the same edge.
            d_q <= dp.escreveM ? r_q : mem_q[e_q];
            p_q <= |dp.botoes;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && dp.escreveM) mem_q[e_q] <= r_q;
    end

`ifdef TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_M);
    logic [TW-1:0] t_q;
    logic          timeout_hit;

    assign timeout_hit = (t_q == TW'(TIMEOUT_M - 1));

    // Freezes (not clears) while a button is held; stops at terminal so the flag sticks.
    always_ff @(posedge clock) begin
        if (!reset || dp.contaE || dp.zeraE) t_q <= '0;
        else if (!(|dp.botoes) && !timeout_hit) t_q <= t_q + 1'b1;
    end

    assign dp.timeout = timeout_hit;
`else
    assign dp.timeout = 1'b0;
`endif

    assign dp.fimE                = (e_q == {A{1'b1}});
    assign dp.fimL                = (l_q == {A{1'b1}});
    assign dp.fimTMR              = (m_q == TMRW'(TMR_M - 1));
    // Reset overrides the buttons so no play strobe escapes while reset is held.
    assign dp.jogada_feita        = reset & (|dp.botoes) & ~p_q;
    assign dp.jogada_valida       = (r_q != '0) && ((r_q & (r_q - 1'b1)) == '0);
    assign dp.chavesIgualMemoria  = (r_q == d_q);
    assign dp.enderecoIgualLimite = (e_q == l_q);
    assign dp.enderecoMenorLimite = (e_q < l_q);
    assign dp.db_tem_jogada       = |dp.botoes;
    assign dp.db_contagem         = e_q;
    assign dp.db_limite           = l_q;
    assign dp.db_jogada           = r_q;
    assign dp.db_memoria          = d_q;
endmodule

// File: tb/tb_fluxo_dados_param.sv
// Directed bench for fluxo_dados_param (N=4, A=4, TIMEOUT_M=8, TMR_M=5).
module tb_fluxo_dados_param;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    fluxo_dados_param_if #(.N(4), .A(4)) dp ();

    fluxo_dados_param #(.N(4), .A(4), .TIMEOUT_M(8), .TMR_M(5)) dut (
        .clock (clock),
        .reset (reset),
        .dp    (dp)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

`ifdef TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    initial begin
        dp.botoes = 4'b1111; dp.zeraE = 0; dp.zeraL = 0; dp.zeraR = 0; dp.zeraTMR = 0;
        dp.contaE = 0; dp.contaL = 0; dp.contaTMR = 0; dp.registraR = 0; dp.escreveM = 0;

        // Reset state, buttons held high throughout
        tick(); tick();
        check_eq("rst_fimE",   32'(dp.fimE), 0);
        check_eq("rst_fimL",   32'(dp.fimL), 0);
        check_eq("rst_fimTMR", 32'(dp.fimTMR), 0);
        check_eq("rst_feita",  32'(dp.jogada_feita), 0);
        check_eq("rst_valida", 32'(dp.jogada_valida), 0);
        check_eq("rst_timeout", 32'(dp.timeout), 0);
        check_eq("rst_igual",  32'(dp.enderecoIgualLimite), 1);
        check_eq("rst_menor",  32'(dp.enderecoMenorLimite), 0);
        check_eq("rst_chaves", 32'(dp.chavesIgualMemoria), 1);
        check_eq("rst_E",      32'(dp.db_contagem), 0);
        check_eq("rst_L",      32'(dp.db_limite), 0);
        check_eq("rst_R",      32'(dp.db_jogada), 0);
        check_eq("rst_D",      32'(dp.db_memoria), 0);

        // Round-1 match
        dp.botoes = 4'b0000; reset = 1'b1;
        tick();
        check_eq("r1_D0", 32'(dp.db_memoria), 'h1);
        dp.botoes = 4'b0001; #1;
        check_eq("r1_feita_hi", 32'(dp.jogada_feita), 1);
        dp.registraR = 1'b1;
        tick();
        dp.registraR = 1'b0; #1;
        check_eq("r1_feita_lo", 32'(dp.jogada_feita), 0);
        check_eq("r1_valida",   32'(dp.jogada_valida), 1);
        check_eq("r1_chaves",   32'(dp.chavesIgualMemoria), 1);
        dp.botoes = 4'b0011; dp.registraR = 1'b1;
        tick();
        dp.registraR = 1'b0; #1;
        check_eq("r1_valida2", 32'(dp.jogada_valida), 0);
        check_eq("r1_chaves2", 32'(dp.chavesIgualMemoria), 0);
        check_eq("r1_feita2",  32'(dp.jogada_feita), 0);

        // Write at E=5 (with contaE in the same cycle) and read back
        dp.botoes = 4'b0100; dp.registraR = 1'b1;
        tick();
        dp.registraR = 1'b0; dp.botoes = 4'b0000; dp.contaE = 1'b1;
        repeat (5) tick();
        check_eq("wr_E5", 32'(dp.db_contagem), 5);
        dp.escreveM = 1'b1;
        tick();
        dp.escreveM = 1'b0; dp.contaE = 1'b0;
        check_eq("wr_E6", 32'(dp.db_contagem), 6);
        check_eq("wr_first", 32'(dp.db_memoria), 'h4);
        dp.zeraE = 1'b1; dp.contaE = 1'b1;
        tick();
        dp.zeraE = 1'b0;
        check_eq("wr_zera_conta", 32'(dp.db_contagem), 0);
        repeat (5) tick();
        dp.contaE = 1'b0;
        check_eq("rd_E5", 32'(dp.db_contagem), 5);
        check_eq("rd_lat_D4", 32'(dp.db_memoria), 'h1);
        tick();
        check_eq("rd_D5", 32'(dp.db_memoria), 'h4);

        // registraR together with zeraR
        dp.botoes = 4'b1000; dp.registraR = 1'b1; dp.zeraR = 1'b1;
        tick();
        dp.registraR = 1'b0; dp.zeraR = 1'b0; dp.botoes = 4'b0000;
        check_eq("zeraR_prio", 32'(dp.db_jogada), 0);

        // Reset mid-run, then limit/wrap flags; memory must survive reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        dp.contaL = 1'b1;
        repeat (3) tick();
        dp.contaL = 1'b0;
        check_eq("lim_L3", 32'(dp.db_limite), 3);
        dp.contaE = 1'b1;
        for (int e = 0; e < 16; e++) begin
            check_eq("walk_E",     32'(dp.db_contagem), 32'(e));
            check_eq("walk_menor", 32'(dp.enderecoMenorLimite), 32'(e < 3));
            check_eq("walk_igual", 32'(dp.enderecoIgualLimite), 32'(e == 3));
            check_eq("walk_fimE",  32'(dp.fimE), 32'(e == 15));
            if (e == 6) check_eq("keep_mem5", 32'(dp.db_memoria), 'h4);
            tick();
        end
        dp.contaE = 1'b0;
        check_eq("wrap_E0",   32'(dp.db_contagem), 0);
        check_eq("wrap_fimE", 32'(dp.fimE), 0);

        // Timeout: 7 idle cycles after a clear
        dp.zeraE = 1'b1;
        tick();
        dp.zeraE = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check_eq("to_idle", 32'(dp.timeout), 32'(TO_ON && i >= 7));
        end
        dp.contaE = 1'b1;
        tick();
        dp.contaE = 1'b0;
        check_eq("to_clear", 32'(dp.timeout), 0);
        // A press freezes T without clearing it: 3 idle + 5 held + 3 idle = T 6, then 7
        dp.zeraE = 1'b1;
        tick();
        dp.zeraE = 1'b0;
        repeat (3) tick();
        dp.botoes = 4'b0010;
        repeat (5) tick();
        dp.botoes = 4'b0000;
        repeat (3) tick();
        check_eq("to_frozen6", 32'(dp.timeout), 0);
        tick();
        check_eq("to_frozen7", 32'(dp.timeout), 32'(TO_ON));

        // Display timer
        dp.contaTMR = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_eq("tmr_fim", 32'(dp.fimTMR), 32'(i % 5 == 4));
        end
        dp.zeraTMR = 1'b1;
        tick();
        dp.zeraTMR = 1'b0;
        check_eq("tmr_zera", 32'(dp.fimTMR), 0);
        repeat (4) tick();
        check_eq("tmr_after_zera", 32'(dp.fimTMR), 1);
        dp.contaTMR = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
